wb_arbiter_2m: RTL and testbench
================================

WB_ARBITER_2M -- requirements
Module: wb_arbiter_2m

Interface
REQ-001 Parameter DWIDTH, default 8, data bus width in bits (multiple of 8).
REQ-002 Parameter AWIDTH, default 16, address bus width in bits.
REQ-003 Parameter TIMEOUT, default 255, stalled-cycle limit before an arbiter-generated error (1..65535).
REQ-004 One clock; reset is asynchronous and active-high.
REQ-005 clk_i  in  1  system clock; all state updates on rising edge.
REQ-006 rst_i  in  1  asynchronous active-high reset.
REQ-007 mN_adr_i  in  AWIDTH  master N address (N = 0, 1; one port per master).
REQ-008 mN_dat_i  in  DWIDTH  master N write data.
REQ-009 mN_we_i / mN_stb_i / mN_cyc_i  in  1 each  master N write enable, strobe, cycle.
REQ-010 mN_sel_i  in  DWIDTH/8  master N byte selects.
REQ-011 mN_dat_o  out  DWIDTH  read data to master N.
REQ-012 mN_ack_o / mN_err_o / mN_rty_o  out  1 each  termination to master N.
REQ-013 s_adr_o, s_dat_o, s_we_o, s_stb_o, s_sel_o, s_cyc_o  out  widths as master inputs  muxed request to the shared slave.
REQ-014 s_dat_i, s_ack_i, s_err_i, s_rty_i  in  DWIDTH,1,1,1  slave response.
REQ-015 gnt_o  out  2  one-hot current grant (bit N = master N); 00 when idle.

Function
REQ-016 FSM states IDLE, GNT0, GNT1; registered; gnt_o decodes state.
REQ-017 A 1-bit last-grant pointer LAST records the master most recently granted.
REQ-018 IDLE: only m0_cyc_i high -> GNT0; only m1_cyc_i high -> GNT1; both high -> grant master != LAST; neither -> stay IDLE.
REQ-019 Grant latency exactly one clock from cyc_i sampled high in IDLE; request reaches slave in the cycle gnt_o is set.
REQ-020 On entry to GNTn, LAST shall be updated to n.
REQ-021 GNTn: s_* outputs shall equal master n inputs combinationally; mN_dat_o of both masters = s_dat_i.
REQ-022 GNTn: mn_ack_o/err_o/rty_o = s_ack_i/s_err_i/s_rty_i; the other master's terminations shall be 0.
REQ-023 GNTn held while mn_cyc_i high (bus lock across multiple strobes); other master's cyc_i ignored.
REQ-024 GNTn with mn_cyc_i low -> IDLE; s_cyc_o/s_stb_o low that cycle; minimum one IDLE cycle between grants.
REQ-025 IDLE: all s_* outputs and all master terminations shall be 0.
REQ-026 16-bit stall counter: in GNTn increments each cycle s_stb_o high with no s_ack_i/s_err_i/s_rty_i; clears on any termination, stb low, or state change.
REQ-027 Counter equal TIMEOUT: mn_err_o = 1 for one cycle, s_stb_o and s_cyc_o forced 0 that cycle, counter cleared, state stays GNTn.
REQ-028 Slave termination arriving on the timeout cycle is dropped; only the error is reported.
REQ-029 Slave termination while s_stb_o low shall not be forwarded.

Reset
REQ-030 rst_i high: state = IDLE, LAST = 1, counter = 0, gnt_o = 00, all s_* outputs and mN_*_o terminations 0 immediately, independent of clk_i.
REQ-031 Reset mid-transfer aborts the cycle without any termination; first grant after release follows REQ-018 with LAST = 1.

Verification
REQ-032 Reset release, m0 and m1 cyc/stb raised same cycle -> gnt_o = 01 next cycle; m1 granted after m0 drops cyc and one IDLE cycle.
REQ-033 m0 write adr 0x1234 dat 0xA5 sel 1, slave acks after 2 waits -> s_adr_o = 0x1234, s_dat_o = 0xA5, m0_ack_o one cycle, m1_ack_o stays 0.
REQ-034 m1 holds cyc over 3 strobes while m0 requests -> gnt_o stays 10 throughout; m0 granted only after m1 cyc drops.
REQ-035 TIMEOUT = 4, slave never responds to m0 -> m0_err_o high exactly one cycle after 4 stalled cycles, s_stb_o low that cycle.
REQ-036 Slave s_err_i and s_rty_i to granted m1 -> forwarded unchanged to m1 only; m0 terminations 0.
REQ-037 rst_i asserted mid-wait-state -> all outputs 0 asynchronously, gnt_o = 00, no ack after release.

Source files
------------

// File: rtl/wb_arbiter_2m.sv
// Two-master Wishbone arbiter: round-robin on contention, bus locked while the granted cyc is held.
// Grant comes one clock after cyc in IDLE and the data path is combinational. A request stalled for TIMEOUT cycles is ended with an error.
module wb_arbiter_2m #(
    parameter int DWIDTH  = 8,
    parameter int AWIDTH  = 16,
    parameter int TIMEOUT = 255
) (
    input  logic                clk_i,
    input  logic                rst_i,

    input  logic [AWIDTH-1:0]   m0_adr_i,
    input  logic [DWIDTH-1:0]   m0_dat_i,
    input  logic                m0_we_i,
    input  logic                m0_stb_i,
    input  logic                m0_cyc_i,
    input  logic [DWIDTH/8-1:0] m0_sel_i,
    output logic [DWIDTH-1:0]   m0_dat_o,
    output logic                m0_ack_o,
    output logic                m0_err_o,
    output logic                m0_rty_o,

    input  logic [AWIDTH-1:0]   m1_adr_i,
    input  logic [DWIDTH-1:0]   m1_dat_i,
    input  logic                m1_we_i,
    input  logic                m1_stb_i,
    input  logic                m1_cyc_i,
    input  logic [DWIDTH/8-1:0] m1_sel_i,
    output logic [DWIDTH-1:0]   m1_dat_o,
    output logic                m1_ack_o,
    output logic                m1_err_o,
    output logic                m1_rty_o,

    output logic [AWIDTH-1:0]   s_adr_o,
    output logic [DWIDTH-1:0]   s_dat_o,
    output logic                s_we_o,
    output logic                s_stb_o,
    output logic [DWIDTH/8-1:0] s_sel_o,
    output logic                s_cyc_o,
    input  logic [DWIDTH-1:0]   s_dat_i,
    input  logic                s_ack_i,
    input  logic                s_err_i,
    input  logic                s_rty_i,

    output logic [1:0]          gnt_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT);

    state_t      state_q, state_d;
    logic        last_q, last_d;
    logic [15:0] stall_q, stall_d;
    logic        timeout;
    logic        slv_term;

    assign timeout  = (state_q != IDLE) && (stall_q == TO_LIMIT);
    assign slv_term = s_ack_i | s_err_i | s_rty_i;

    // State, last-grant pointer and stall counter registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            stall_q <= 16'd0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            stall_q <= stall_d;
        end
    end

    // Next-state: on contention the master that did not win last time goes first
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    state_d = last_q ? GNT0 : GNT1;
                end else if (m0_cyc_i) begin
                    state_d = GNT0;
                end else if (m1_cyc_i) begin
                    state_d = GNT1;
                end
            end
            GNT0: begin
                if (!m0_cyc_i) begin
                    state_d = IDLE;
                end
            end
            GNT1: begin
                if (!m1_cyc_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (state_q == IDLE && state_d == GNT0) begin
            last_d = 1'b0;
        end else if (state_q == IDLE && state_d == GNT1) begin
            last_d = 1'b1;
        end
    end

    // Stall counter only runs while a strobe is outstanding on an unchanged grant
    always_comb begin
        stall_d = 16'd0;
        if (state_d == state_q && state_q != IDLE && !timeout &&
            s_stb_o && !slv_term) begin
            stall_d = stall_q + 16'd1;
        end
    end

    // Outputs: request mux, termination routing, grant decode
    always_comb begin
        s_adr_o  = '0;
        s_dat_o  = '0;
        s_we_o   = 1'b0;
        s_sel_o  = '0;
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        m0_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m0_rty_o = 1'b0;
        m1_ack_o = 1'b0;
        m1_err_o = 1'b0;
        m1_rty_o = 1'b0;
        gnt_o    = 2'b00;
        m0_dat_o = s_dat_i;
        m1_dat_o = s_dat_i;
        case (state_q)
            GNT0: begin
                gnt_o    = 2'b01;
                s_adr_o  = m0_adr_i;
                s_dat_o  = m0_dat_i;
                s_we_o   = m0_we_i;
                s_sel_o  = m0_sel_i;
                s_cyc_o  = m0_cyc_i & ~timeout;
                s_stb_o  = m0_cyc_i & m0_stb_i & ~timeout;
                m0_ack_o = s_ack_i & s_stb_o;
                m0_err_o = (s_err_i & s_stb_o) | timeout;
                m0_rty_o = s_rty_i & s_stb_o;
            end
            GNT1: begin
                gnt_o    = 2'b10;
                s_adr_o  = m1_adr_i;
                s_dat_o  = m1_dat_i;
                s_we_o   = m1_we_i;
                s_sel_o  = m1_sel_i;
                s_cyc_o  = m1_cyc_i & ~timeout;
                s_stb_o  = m1_cyc_i & m1_stb_i & ~timeout;
                m1_ack_o = s_ack_i & s_stb_o;
                m1_err_o = (s_err_i & s_stb_o) | timeout;
                m1_rty_o = s_rty_i & s_stb_o;
            end
            default: begin
                gnt_o = 2'b00;
            end
        endcase
    end

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Directed bench for wb_arbiter_2m: per-cycle vector table plus hand sequences for data, timeout and reset.
module tb_wb_arbiter_2m;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [15:0] m0_adr_i = '0, m1_adr_i = '0, s_adr_o;
    logic [7:0]  m0_dat_i = '0, m1_dat_i = '0, m0_dat_o, m1_dat_o, s_dat_o, s_dat_i = '0;
    logic        m0_we_i = 0, m0_stb_i = 0, m0_cyc_i = 0, m1_we_i = 0, m1_stb_i = 0, m1_cyc_i = 0;
    logic [0:0]  m0_sel_i = '0, m1_sel_i = '0, s_sel_o;
    logic        m0_ack_o, m0_err_o, m0_rty_o, m1_ack_o, m1_err_o, m1_rty_o;
    logic        s_we_o, s_stb_o, s_cyc_o;
    logic        s_ack_i = 0, s_err_i = 0, s_rty_i = 0;
    logic [1:0]  gnt_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    wb_arbiter_2m #(.DWIDTH(8), .AWIDTH(16), .TIMEOUT(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_we_i(m0_we_i), .m0_stb_i(m0_stb_i),
        .m0_cyc_i(m0_cyc_i), .m0_sel_i(m0_sel_i), .m0_dat_o(m0_dat_o),
        .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_rty_o(m0_rty_o),
        .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_we_i(m1_we_i), .m1_stb_i(m1_stb_i),
        .m1_cyc_i(m1_cyc_i), .m1_sel_i(m1_sel_i), .m1_dat_o(m1_dat_o),
        .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_rty_o(m1_rty_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_we_o(s_we_o), .s_stb_o(s_stb_o),
        .s_sel_o(s_sel_o), .s_cyc_o(s_cyc_o), .s_dat_i(s_dat_i),
        .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i),
        .gnt_o(gnt_o)
    );

    typedef struct {
        logic [6:0] in;   // {c0, s0, c1, s1, ack, err, rty}
        logic [8:0] exp;  // {gnt[1:0], scyc, sstb, m0ack, m0err, m1ack, m1err, m1rty}
    } vec_t;

    vec_t vecs[18];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    function automatic logic [8:0] obs();
        return {gnt_o, s_cyc_o, s_stb_o, m0_ack_o, m0_err_o, m1_ack_o, m1_err_o, m1_rty_o};
    endfunction

    initial begin
        //                  c0 s0 c1 s1 a e r       gnt cy st 0a 0e 1a 1e 1r
        vecs[0]  = '{7'b1111000, 9'b01_1_1_0_0_0_0_0}; // both request, LAST=1 -> m0
        vecs[1]  = '{7'b1111100, 9'b01_1_1_1_0_0_0_0}; // ack to m0 only
        vecs[2]  = '{7'b0011000, 9'b00_0_0_0_0_0_0_0}; // m0 drops cyc -> IDLE
        vecs[3]  = '{7'b0011000, 9'b10_1_1_0_0_0_0_0}; // m1 after one idle cycle
        vecs[4]  = '{7'b1111100, 9'b10_1_1_0_0_1_0_0}; // m1 locked, m0 ignored
        vecs[5]  = '{7'b1110100, 9'b10_1_0_0_0_0_0_0}; // ack with stb low dropped
        vecs[6]  = '{7'b1111100, 9'b10_1_1_0_0_1_0_0};
        vecs[7]  = '{7'b1111010, 9'b10_1_1_0_0_0_1_0}; // err to m1 only
        vecs[8]  = '{7'b1111001, 9'b10_1_1_0_0_0_0_1}; // rty to m1 only
        vecs[9]  = '{7'b1100000, 9'b00_0_0_0_0_0_0_0};
        vecs[10] = '{7'b1100000, 9'b01_1_1_0_0_0_0_0};
        vecs[11] = '{7'b1111100, 9'b01_1_1_1_0_0_0_0};
        vecs[12] = '{7'b0011000, 9'b00_0_0_0_0_0_0_0};
        vecs[13] = '{7'b1111000, 9'b10_1_1_0_0_0_0_0}; // LAST=0 -> m1 wins
        vecs[14] = '{7'b1100000, 9'b00_0_0_0_0_0_0_0};
        vecs[15] = '{7'b1111000, 9'b01_1_1_0_0_0_0_0}; // LAST=1 -> m0 wins
        vecs[16] = '{7'b0000000, 9'b00_0_0_0_0_0_0_0};
        vecs[17] = '{7'b0000111, 9'b00_0_0_0_0_0_0_0}; // IDLE blocks terminations

        #3;
        chk("reset_outputs", {23'd0, obs()}, 32'd0);
        chk("reset_sadr", {16'd0, s_adr_o}, 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;

        for (int i = 0; i < 18; i++) begin
            @(negedge clk_i);
            {m0_cyc_i, m0_stb_i, m1_cyc_i, m1_stb_i, s_ack_i, s_err_i, s_rty_i} = vecs[i].in;
            @(posedge clk_i);
            #1;
            chk($sformatf("vec%0d", i), {23'd0, obs()}, {23'd0, vecs[i].exp});
        end

        // m0 write with two wait states
        @(negedge clk_i);
        {s_ack_i, s_err_i, s_rty_i} = 3'b000;
        m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 1;
        m0_adr_i = 16'h1234; m0_dat_i = 8'hA5; m0_sel_i = 1'b1; s_dat_i = 8'h3C;
        @(posedge clk_i); #1;
        chk("wr_gnt", {30'd0, gnt_o}, 32'd1);
        chk("wr_adr", {16'd0, s_adr_o}, 32'h1234);
        chk("wr_dat", {24'd0, s_dat_o}, 32'hA5);
        chk("wr_we_sel", {30'd0, s_we_o, s_sel_o}, 32'd3);
        chk("rd_dat_both", {16'd0, m0_dat_o, m1_dat_o}, 32'h3C3C);
        chk("wait1_ack", {30'd0, m0_ack_o, m1_ack_o}, 32'd0);
        @(posedge clk_i); #1;
        chk("wait2_ack", {30'd0, m0_ack_o, m1_ack_o}, 32'd0);
        @(negedge clk_i);
        s_ack_i = 1;
        @(posedge clk_i); #1;
        chk("wr_ack", {30'd0, m0_ack_o, m1_ack_o}, 32'd2);
        @(negedge clk_i);
        s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
        #1;
        chk("drop_cyc_same_cycle", {29'd0, gnt_o, s_cyc_o}, 32'd2);
        @(posedge clk_i); #1;
        chk("wr_done_idle", {23'd0, obs()}, 32'd0);

        // Timeout: slave never answers m0
        @(negedge clk_i);
        m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 0;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk_i); #1;
            chk($sformatf("stall%0d", k), {29'd0, m0_err_o, s_stb_o, s_cyc_o}, 32'd3);
        end
        @(posedge clk_i); #1;
        chk("timeout_err", {23'd0, obs()}, {23'd0, 9'b01_0_0_0_1_0_0_0});
        s_ack_i = 1;
        #1;
        chk("timeout_drops_ack", {30'd0, m0_ack_o, m0_err_o}, 32'd1);
        @(negedge clk_i);
        s_ack_i = 0;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk_i); #1;
            chk($sformatf("restall%0d", k), {27'd0, gnt_o, m0_err_o, s_stb_o, s_cyc_o}, 32'h0B);
        end
        @(posedge clk_i); #1;
        chk("timeout_again", {29'd0, m0_err_o, s_stb_o, s_cyc_o}, 32'd4);

        // Reset in the middle of a wait state
        @(posedge clk_i); #1;
        chk("pre_reset_wait", {30'd0, gnt_o}, 32'd1);
        @(negedge clk_i);
        #2;
        rst_i = 1; s_ack_i = 1;
        #1;
        chk("async_reset", {23'd0, obs()}, 32'd0);
        @(negedge clk_i);
        rst_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk_i); #1;
            chk($sformatf("post_reset%0d", k), {23'd0, obs()}, 32'd0);
        end
        @(negedge clk_i);
        s_ack_i = 0;
        m0_cyc_i = 1; m0_stb_i = 1; m1_cyc_i = 1; m1_stb_i = 1;
        @(posedge clk_i); #1;
        chk("first_gnt_after_reset", {30'd0, gnt_o}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
